// File: rtl/coin_pkg.sv
// coin_pkg: shared types and helpers for the coin event encoder.
// Channel enumeration, default channel count and the priority/code helpers
// used by coin_event_encoder.
package coin_pkg;

  // Coin channels in ascending value; a higher index wins arbitration.
  typedef enum logic [1:0] {
    COIN_FARTHING = 2'd0,
    COIN_HAPENNY  = 2'd1,
    COIN_PENNY    = 2'd2
  } coin_e;

  localparam int NUM_COINS_DEFAULT = 3;

  // Widest channel vector the helpers handle (index fits in 4 bits).
  localparam int MAX_COINS = 15;

  // Output code for a channel index: index+1, so that 0 means "no coin".
  function automatic logic [3:0] code_of(input logic [3:0] index);
    return index + 4'd1;
  endfunction

  // Index of the most significant set bit; 0 when the vector is empty.
  function automatic logic [3:0] highest_set(input logic [MAX_COINS-1:0] vec);
    logic [3:0] idx;
    idx = '0;
    for (int i = 0; i < MAX_COINS; i++) begin
      if (vec[i]) idx = 4'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/coin_debounce.sv
// coin_debounce: single-channel level filter.
// The filtered level follows the input only after the input has disagreed
// with it for DEBOUNCE_CYCLES consecutive clocks; any agreeing sample
// restarts the count. Used by coin_event_encoder when COIN_DEBOUNCE_EN is set.
module coin_debounce #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic dout
);

  localparam int CNT_W = (DEBOUNCE_CYCLES < 1) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [CNT_W-1:0] cnt;

  // Count consecutive mismatches; flip the filtered level on the last one.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt  <= '0;
      dout <= 1'b0;
    end else if (din != dout) begin
      if (cnt == CNT_LAST) begin
        dout <= din;
        cnt  <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end else begin
      cnt <= '0;
    end
  end

endmodule

// File: rtl/coin_event_encoder.sv
// coin_event_encoder: turns raw coin-sensor levels into a stream of coin
// codes (channel index + 1) on a valid/ready port.
// Each sensor bit is synchronised, rising edges are detected and held in a
// per-channel pending latch, and the highest pending channel is presented
// first. A rise on a channel that is already pending is lost and flagged
// on the sticky overrun output.
// Optional build macro: COIN_DEBOUNCE_EN inserts a coin_debounce filter
// after each synchroniser (DEBOUNCE_CYCLES stable samples).
//
// Handshake: code_out/code_valid are registered. A code is transferred on a
// clock edge where code_valid and code_ready are both 1. While code_valid is
// 1 and code_ready is 0, code_out and code_valid hold. A new code may be
// loaded on the same edge that accepts the previous one (1 event per clock).
module coin_event_encoder
  import coin_pkg::*;
#(
  parameter int  NUM_COINS       = NUM_COINS_DEFAULT,
  parameter int  DEBOUNCE_CYCLES = 4,
  localparam int CODE_W          = $clog2(NUM_COINS + 1)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_COINS-1:0] coin_in,
  output logic [CODE_W-1:0]    code_out,
  output logic                 code_valid,
  input  logic                 code_ready,
  output logic                 overrun,
  input  logic                 overrun_clr,
  output logic [NUM_COINS-1:0] pending
);

  logic [NUM_COINS-1:0] sync1;
  logic [NUM_COINS-1:0] sync2;
  logic [NUM_COINS-1:0] level;
  logic [NUM_COINS-1:0] prev;
  logic [NUM_COINS-1:0] rise;
  logic [NUM_COINS-1:0] req;
  logic [NUM_COINS-1:0] grant_oh;
  logic [NUM_COINS-1:0] keep;
  logic [NUM_COINS-1:0] drop;
  logic [NUM_COINS-1:0] pending_next;
  logic                 load;
  logic                 any_req;
  logic [3:0]           grant_idx;

  // Two-flop synchroniser per sensor bit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= coin_in;
      sync2 <= sync1;
    end
  end

`ifdef COIN_DEBOUNCE_EN
  // One debouncer per channel on the synchronised level.
  for (genvar i = 0; i < NUM_COINS; i++) begin : g_debounce
    coin_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .clk  (clk),
      .reset(reset),
      .din  (sync2[i]),
      .dout (level[i])
    );
  end
`else
  // Without the filter the edge detector sees the synchronised level.
  assign level = sync2;

  logic unused_debounce_cfg;
  assign unused_debounce_cfg = ^DEBOUNCE_CYCLES;
`endif

  // Previous filtered level for rising-edge detection.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev <= '0;
    end else begin
      prev <= level;
    end
  end

  // Edge detect, arbitration and next pending state.
  always_comb begin
    rise      = level & ~prev;
    req       = pending | rise;
    any_req   = |req;
    load      = !code_valid || code_ready;
    grant_idx = highest_set(MAX_COINS'(req));
    grant_oh  = '0;
    if (load && any_req) begin
      grant_oh = NUM_COINS'(1) << grant_idx;
    end
    // The granted channel's older event is consumed; a fresh rise on that
    // same channel survives as the next pending event, not an overrun.
    keep         = rise & pending & grant_oh;
    // Any other rise onto an already pending channel is lost.
    drop         = rise & pending & ~grant_oh;
    pending_next = (req & ~grant_oh) | keep;
  end

  // Output register, pending latches and sticky overrun flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      code_out   <= '0;
      code_valid <= 1'b0;
      pending    <= '0;
      overrun    <= 1'b0;
    end else begin
      pending <= pending_next;
      // A new overrun in the same cycle as a clear keeps the flag set.
      overrun <= (|drop) | (overrun & ~overrun_clr);
      if (load) begin
        if (any_req) begin
          code_out   <= CODE_W'(code_of(grant_idx));
          code_valid <= 1'b1;
        end else begin
          code_valid <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_coin_event_encoder.sv
// tb_coin_event_encoder: self-checking bench for coin_event_encoder.
// Table-driven vectors, hand-written multi-cycle sequences and a randomized
// phase checked against a behavioural model of the encoder's rules.
module tb_coin_event_encoder;

  localparam int N  = 3;
  localparam int CW = 2;

  // ---------------- clock / reset / DUT ----------------
  logic          clk = 1'b0;
  logic          reset;
  logic [N-1:0]  coin_in;
  logic [CW-1:0] code_out;
  logic          code_valid;
  logic          code_ready;
  logic          overrun;
  logic          overrun_clr;
  logic [N-1:0]  pending;

  always #5 clk = ~clk;

  coin_event_encoder #(
    .NUM_COINS      (N),
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .coin_in    (coin_in),
    .code_out   (code_out),
    .code_valid (code_valid),
    .code_ready (code_ready),
    .overrun    (overrun),
    .overrun_clr(overrun_clr),
    .pending    (pending)
  );

  int tests_run    = 0;
  int tests_failed = 0;

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [N-1:0] c, input logic r, input logic clr);
    coin_in     = c;
    code_ready  = r;
    overrun_clr = clr;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // One-cycle sensor pulse followed by three idle cycles.
  task automatic pulse(input logic [N-1:0] c);
    coin_in = c;
    tick();
    coin_in = '0;
    repeat (3) tick();
  endtask

  task automatic do_reset();
    #2;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  // ---------------- behavioural model + scoreboard ----------------
  logic [N-1:0]  hist[$];
  logic [N-1:0]  m_pend;
  logic          m_valid;
  logic [CW-1:0] m_code;
  logic          m_ovr;
  logic [CW-1:0] exp_q[$];

  task automatic model_reset();
    hist = {};
    repeat (3) hist.push_back('0);
    m_pend  = '0;
    m_valid = 1'b0;
    m_code  = '0;
    m_ovr   = 1'b0;
    exp_q   = {};
  endtask

  // Apply one clock edge to the model with the inputs sampled at that edge.
  // The edge detector sees the sample from two edges back against the one
  // before it; the highest requesting channel is presented next.
  task automatic model_edge(input logic [N-1:0] c, input logic r, input logic clr);
    logic [N-1:0] rise;
    logic [N-1:0] req;
    logic [N-1:0] np;
    logic         can_load;
    logic         set;
    int           g;
    rise = hist[1] & ~hist[0];
    hist.push_back(c);
    void'(hist.pop_front());
    req      = m_pend | rise;
    can_load = !m_valid || r;
    g        = -1;
    if (can_load) begin
      for (int i = 0; i < N; i++) if (req[i]) g = i;
    end
    set = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (i == g) begin
        np[i] = rise[i] && m_pend[i];
      end else begin
        np[i] = req[i];
        if (rise[i] && m_pend[i]) set = 1'b1;
      end
    end
    if (can_load) begin
      if (g >= 0) begin
        m_valid = 1'b1;
        m_code  = CW'(g + 1);
        exp_q.push_back(m_code);
      end else begin
        m_valid = 1'b0;
      end
    end
    m_pend = np;
    m_ovr  = set | (m_ovr & ~clr);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [N-1:0]  coin;
    logic          ready;
    logic          clr;
    logic          ev;
    logic [CW-1:0] ec;
    logic [N-1:0]  ep;
    logic          eo;
  } vec_t;

  vec_t tbl[15];

  function automatic vec_t mk(input logic [N-1:0] c, input logic r, input logic clr,
                              input logic ev, input logic [CW-1:0] ec,
                              input logic [N-1:0] ep, input logic eo);
    vec_t v;
    v.coin = c; v.ready = r; v.clr = clr;
    v.ev = ev; v.ec = ec; v.ep = ep; v.eo = eo;
    return v;
  endfunction

  // ---------------- test sequence ----------------
  initial begin
    int hs;
    int other;
    int seen;
    logic [N-1:0] cur;

    reset = 1'b1;
    drive('0, 1'b0, 1'b0);
    tick();
    tick();
    check("rst_valid",   code_valid, 0);
    check("rst_code",    code_out,   0);
    check("rst_pending", pending,    0);
    check("rst_overrun", overrun,    0);
    reset = 1'b0;

`ifndef COIN_DEBOUNCE_EN
    // Single farthing pulse, then all three channels at once (ready=1).
    tbl[0]  = mk(3'b001, 1, 0, 0, 0, 3'b000, 0);
    tbl[1]  = mk(3'b001, 1, 0, 0, 0, 3'b000, 0);
    tbl[2]  = mk(3'b001, 1, 0, 1, 1, 3'b000, 0);
    tbl[3]  = mk(3'b001, 1, 0, 0, 0, 3'b000, 0);
    tbl[4]  = mk(3'b001, 1, 0, 0, 0, 3'b000, 0);
    tbl[5]  = mk(3'b000, 1, 0, 0, 0, 3'b000, 0);
    tbl[6]  = mk(3'b000, 1, 0, 0, 0, 3'b000, 0);
    tbl[7]  = mk(3'b000, 1, 0, 0, 0, 3'b000, 0);
    tbl[8]  = mk(3'b111, 1, 0, 0, 0, 3'b000, 0);
    tbl[9]  = mk(3'b000, 1, 0, 0, 0, 3'b000, 0);
    tbl[10] = mk(3'b000, 1, 0, 1, 3, 3'b011, 0);
    tbl[11] = mk(3'b000, 1, 0, 1, 2, 3'b001, 0);
    tbl[12] = mk(3'b000, 1, 0, 1, 1, 3'b000, 0);
    tbl[13] = mk(3'b000, 1, 0, 0, 0, 3'b000, 0);
    tbl[14] = mk(3'b000, 1, 1, 0, 0, 3'b000, 0);

    for (int i = 0; i < 15; i++) begin
      drive(tbl[i].coin, tbl[i].ready, tbl[i].clr);
      tick();
      check($sformatf("tbl%0d_valid", i), code_valid, tbl[i].ev);
      if (tbl[i].ev) check($sformatf("tbl%0d_code", i), code_out, tbl[i].ec);
      check($sformatf("tbl%0d_pending", i), pending, tbl[i].ep);
      check($sformatf("tbl%0d_overrun", i), overrun, tbl[i].eo);
    end

    // Back-pressure: penny code must hold for 10 clocks, then go once.
    drive('0, 1'b0, 1'b0);
    pulse(3'b100);
    for (int t = 0; t < 10; t++) begin
      check("t3_hold_valid", code_valid, 1);
      check("t3_hold_code",  code_out,   3);
      tick();
    end
    code_ready = 1'b1;
    tick();
    check("t3_accept_valid", code_valid, 0);
    tick();
    check("t3_after_valid", code_valid, 0);

    // Overrun: presented + pending farthing, third pulse is lost.
    drive('0, 1'b0, 1'b0);
    pulse(3'b001);
    check("t4_p1_valid", code_valid, 1);
    check("t4_p1_code",  code_out,   1);
    check("t4_p1_pend",  pending,    0);
    pulse(3'b001);
    check("t4_p2_pend",  pending,    3'b001);
    check("t4_p2_ovr",   overrun,    0);
    pulse(3'b001);
    check("t4_p3_ovr",   overrun,    1);
    check("t4_p3_pend",  pending,    3'b001);
    overrun_clr = 1'b1;
    tick();
    overrun_clr = 1'b0;
    check("t4_clr_ovr",  overrun,    0);
    hs    = 0;
    other = 0;
    code_ready = 1'b1;
    for (int t = 0; t < 5; t++) begin
      if (code_valid && code_ready) begin
        if (code_out == 2'd1) hs++;
        else other++;
      end
      tick();
    end
    check("t4_farthing_count", hs,    2);
    check("t4_other_count",    other, 0);
    check("t4_end_valid",      code_valid, 0);

    // Asynchronous reset with a presented code and two pending channels.
    drive('0, 1'b0, 1'b0);
    pulse(3'b001);
    pulse(3'b110);
    check("t5_pre_pend",  pending,    3'b110);
    check("t5_pre_valid", code_valid, 1);
    #2;
    reset = 1'b1;
    #1;
    check("t5_async_valid", code_valid, 0);
    check("t5_async_code",  code_out,   0);
    check("t5_async_pend",  pending,    0);
    check("t5_async_ovr",   overrun,    0);
    tick();
    reset = 1'b0;
    code_ready = 1'b1;
    seen = 0;
    for (int t = 0; t < 6; t++) begin
      tick();
      if (code_valid) seen++;
    end
    check("t5_no_codes", seen, 0);

    // Randomized run against the model; accepted codes scored in order.
    drive('0, 1'b0, 1'b0);
    do_reset();
    model_reset();
    cur = '0;
    for (int t = 0; t < 400; t++) begin
      for (int b = 0; b < N; b++) begin
        if ($urandom_range(0, 3) == 0) cur[b] = ~cur[b];
      end
      drive(cur, ($urandom_range(0, 3) != 0), ($urandom_range(0, 15) == 0));
      if (code_valid && code_ready) begin
        if (exp_q.size() == 0) begin
          check("rnd_unexpected_accept", code_out, 'hff);
        end else begin
          check("rnd_accept_code", code_out, exp_q.pop_front());
        end
      end
      model_edge(coin_in, code_ready, overrun_clr);
      tick();
      check("rnd_valid",   code_valid, m_valid);
      if (m_valid) check("rnd_code", code_out, m_code);
      check("rnd_pending", pending,    m_pend);
      check("rnd_overrun", overrun,    m_ovr);
    end
`else
    // Debounced build: short glitch ignored, long pulse delayed by 4 clocks.
    drive('0, 1'b1, 1'b0);
    seen = 0;
    for (int t = 1; t <= 15; t++) begin
      coin_in = (t <= 3) ? 3'b001 : 3'b000;
      tick();
      if (code_valid) seen++;
    end
    check("t6_glitch_events", seen, 0);
    seen = 0;
    for (int t = 1; t <= 14; t++) begin
      coin_in = (t <= 6) ? 3'b001 : 3'b000;
      tick();
      if (code_valid) seen++;
      check($sformatf("t6_valid_t%0d", t), code_valid, (t == 7));
      if (t == 7) check("t6_code", code_out, 1);
    end
    check("t6_event_count", seen, 1);
    check("t6_overrun", overrun, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
